// File: rtl/calc_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_display_driver_if
// Brief    : Display bundle between the calculator core and the 7-segment
//            driver: value/flags/status in, segment/anode pin drive out.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_display_driver_if;
   logic [15:0] ToDisplay;
   logic [3:0]  Flags;
   logic [2:0]  Status;
   logic [6:0]  Segments;
   logic        DP;
   logic [7:0]  Anodes;

   // Calculator side: produces the values, observes the pin drive.
   modport master (
      output ToDisplay, Flags, Status,
      input  Segments, DP, Anodes
   );

   // Display driver side.
   modport slave (
      input  ToDisplay, Flags, Status,
      output Segments, DP, Anodes
   );
endinterface
`default_nettype wire

// File: rtl/calc_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc_display_driver
// Brief    : Time-multiplexes a 16-bit hex value, 4 flag bits (on decimal
//            points) and a 3-bit status digit onto an 8-digit common-anode,
//            active-low 7-segment display. Inputs are latched once per
//            refresh frame so a frame never mixes old and new digits.
// Options  : CALC_DISPLAY_LZ_BLANK_EN - blank leading zeros on digits 3..1.
// Revision : 1.0 - initial release
// ============================================================================
module calc_display_driver #(
   parameter int REFRESH_DIV = 100000,   // clock cycles per digit slot, >= 2
   parameter int N_DIGITS    = 8         // anodes scanned; only 8 supported
) (
   input wire clk,
   input wire reset,
   calc_display_driver_if.slave disp
);

   localparam int                    c_PRE_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_PRE_W-1:0]    c_PRE_MAX    = c_PRE_W'(REFRESH_DIV - 1);
   localparam logic [2:0]            c_LAST_DIGIT = 3'(N_DIGITS - 1);
   localparam logic [6:0]            c_SEG_BLANK  = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   logic [c_PRE_W-1:0]  r_prescaler;
   logic [2:0]          r_digit_idx;
   logic [15:0]         r_value;
   logic [3:0]          r_flags;
   logic [2:0]          r_status;

   logic [N_DIGITS-1:0] r_anodes;
   logic [6:0]          r_segments;
   logic                r_dp;

   logic                w_tick;
   logic                w_frame_end;
   logic [3:0]          w_nibble;
   logic                w_show_digit;
   logic                w_lz_blank;
   logic                w_dp_n;
   logic [6:0]          w_segments;
   logic [N_DIGITS-1:0] w_anodes;

   assign w_tick      = (r_prescaler == c_PRE_MAX);
   assign w_frame_end = w_tick && (r_digit_idx == c_LAST_DIGIT);

   // Slot timing, digit scan and once-per-frame input snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prescaler <= '0;
         r_digit_idx <= 3'd0;
         r_value     <= 16'h0000;
         r_flags     <= 4'h0;
         r_status    <= 3'd0;
      end else begin
         if (w_tick) begin
            r_prescaler <= '0;
            r_digit_idx <= r_digit_idx + 3'd1;
         end else begin
            r_prescaler <= r_prescaler + c_PRE_W'(1);
         end
         // Sample the live inputs on the last slot of the frame so the
         // next frame is drawn entirely from one consistent set.
         if (w_frame_end) begin
            r_value  <= disp.ToDisplay;
            r_flags  <= disp.Flags;
            r_status <= disp.Status;
         end
      end
   end

   // Select nibble, visibility and decimal point for the digit being scanned.
   always_comb begin
      w_nibble     = 4'h0;
      w_show_digit = 1'b0;
      w_dp_n       = 1'b1;
      case (r_digit_idx)
         3'd0: begin
            w_nibble     = r_value[3:0];
            w_show_digit = 1'b1;
            w_dp_n       = ~r_flags[0];
         end
         3'd1: begin
            w_nibble     = r_value[7:4];
            w_show_digit = 1'b1;
            w_dp_n       = ~r_flags[1];
         end
         3'd2: begin
            w_nibble     = r_value[11:8];
            w_show_digit = 1'b1;
            w_dp_n       = ~r_flags[2];
         end
         3'd3: begin
            w_nibble     = r_value[15:12];
            w_show_digit = 1'b1;
            w_dp_n       = ~r_flags[3];
         end
         3'd4: begin
            w_nibble     = {1'b0, r_status};
            w_show_digit = 1'b1;
         end
         default: begin
            w_nibble     = 4'h0;
            w_show_digit = 1'b0;
         end
      endcase
   end

`ifdef CALC_DISPLAY_LZ_BLANK_EN
   // A value digit is a leading zero when it and every higher nibble are 0;
   // digit 0 always shows so a zero value still reads "0".
   always_comb begin
      w_lz_blank = 1'b0;
      case (r_digit_idx)
         3'd1:    w_lz_blank = (r_value[15:4]  == 12'h000);
         3'd2:    w_lz_blank = (r_value[15:8]  == 8'h00);
         3'd3:    w_lz_blank = (r_value[15:12] == 4'h0);
         default: w_lz_blank = 1'b0;
      endcase
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   assign w_segments = (w_show_digit && !w_lz_blank) ? hex_to_seg(w_nibble) : c_SEG_BLANK;
   assign w_anodes   = ~(N_DIGITS'(1) << r_digit_idx);

   // Registered pin drive: reflects the digit selected on the previous cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_anodes   <= '1;
         r_segments <= c_SEG_BLANK;
         r_dp       <= 1'b1;
      end else begin
         r_anodes   <= w_anodes;
         r_segments <= w_segments;
         r_dp       <= w_dp_n;
      end
   end

   assign disp.Anodes   = r_anodes;
   assign disp.Segments = r_segments;
   assign disp.DP       = r_dp;

endmodule
`default_nettype wire

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
- Consumer side of the RPN calculator's display interface. Takes the calculator's 16-bit display value, 4-bit ALU flags and 3-bit FSM status.
- Time-multiplexes them onto an 8-digit, common-anode, active-low 7-segment display.
- Sits between the calculator top level and the board pins.
- Latches its inputs once per refresh frame, so a value that changes mid-frame never shows a mix of old and new digits.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be ≥ 2. Use 4 in simulation.
- N_DIGITS, 8: number of anodes scanned. Fixed at 8; other values are unsupported.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ToDisplay  input  16  value shown as 4 hex digits
- Flags  input  4  ALU flags, shown on decimal points
- Status  input  3  calculator FSM status, shown as one digit
- Segments  output  7  {g,f,e,d,c,b,a}, active-low
- DP  output  1  decimal point, active-low
- Anodes  output  8  digit enables, active-low, one-hot-low

Behaviour:
- Prescaler
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index (3 bits)
  - Advances by 1 on tick; wraps from 7 to 0.
- Snapshot register (value 16, flags 4, status 3)
  - Loads ToDisplay, Flags and Status when tick && digit_idx == 7, i.e. at the frame boundary.
  - Holds otherwise.
- Digit mapping for the current digit_idx:
  - 0..3: hex nibble value[4*idx+3 : 4*idx]. DP lit iff flags[idx].
  - 4: status, zero-extended to a nibble. DP off.
  - 5..7: blank (Segments = 7'h7F). DP off.
- Hex encoding, active-low:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Outputs are registered:
  - Anodes = ~(8'b1 << digit_idx), Segments and DP all reflect digit_idx one clock later.
  - Exactly one Anodes bit is low at every cycle after the first post-reset clock.
- Reset (synchronous, dominates every other event in the same cycle):
  - prescaler = 0, digit_idx = 0, snapshot = 0.
  - Anodes = 8'hFF, Segments = 7'h7F, DP = 1 (all off).
- Reset mid-frame: scan restarts at digit 0 and the snapshot is cleared, so the display reads "0000" and status 0 until the first frame boundary.
- Input changes between frame boundaries have no effect on the outputs.
- An input change in the same cycle as the capture tick is captured, because the snapshot samples the current input values.

Optional Feature:
- Macro: CALC_DISPLAY_LZ_BLANK_EN
- Defined: leading-zero blanking on digits 3..1.
  - A digit is blanked (Segments = 7'h7F) when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The DP of a blanked digit still follows its flag.
- Undefined: all four value digits are always shown, including leading zeros.
- The status digit is unaffected in both cases.

Test Plan:
- REFRESH_DIV=4; hold reset 3 cycles → Anodes=FF, Segments=7F, DP=1. After release, Anodes steps FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles, then repeats.
- ToDisplay=16'h1A3F, Flags=4'b0101, Status=3'd5, applied before a frame boundary → next frame shows:
  - digit0 Segments=0E, DP=0
  - digit1 Segments=30, DP=1
  - digit2 Segments=08, DP=0
  - digit3 Segments=79, DP=1
  - digit4 Segments=12
  - digits5-7 Segments=7F
- Change ToDisplay from 16'h1234 to 16'hFFFF while digit_idx=2 → the rest of the current frame still shows 1234; the next frame shows FFFF on all four value digits.
- Assert reset for 1 cycle while digit_idx=5 → next cycle all outputs are off; scan resumes at digit 0 showing 0 (Segments=40) until the next frame boundary.
- With CALC_DISPLAY_LZ_BLANK_EN, ToDisplay=16'h0007, Flags=0 → digits3..1 Segments=7F, digit0 Segments=78. Without the macro, digits3..1 Segments=40.
- Over 1000 cycles of random input changes → Anodes is always one-hot-low, and Segments/DP match the mapping for the digit selected on the previous cycle.
